// File: rtl/perf_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : perf_packer_pkg
//  Purpose  : Shared types and sizing helpers for the performance counter
//             stream packer (beat geometry, FSM state type, field widths).
//  Revision : 1.0 - initial release
// ============================================================================
package perf_packer_pkg;

  localparam int TIMESTAMP_WIDTH = 64;
  localparam int DROPPED_WIDTH   = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of whole counters that fit in one stream beat.
  function automatic int calc_cpb(input int data_width, input int counter_width);
    return data_width / counter_width;
  endfunction

  // Number of counter beats needed to carry every counter once.
  function automatic int calc_num_beats(input int num_counters, input int data_width,
                                        input int counter_width);
    int cpb;
    cpb = data_width / counter_width;
    return (num_counters + cpb - 1) / cpb;
  endfunction

  // Bits required to index 0..count-1, never less than one.
  function automatic int idx_width(input int count);
    int w;
    w = 1;
    while ((1 << w) < count) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_beat_select.sv
`default_nettype none
// ============================================================================
//  Module   : perf_beat_select
//  Purpose  : Combinational slice selector. Given the frozen counter snapshot
//             and a counter-beat index, returns that beat's counters packed
//             LSB-first into COUNTER_WIDTH lanes, zero padded above the last
//             lane and for lanes past the final counter.
//  Revision : 1.0 - initial release
// ============================================================================
module perf_beat_select
  import perf_packer_pkg::*;
#(
  parameter int NUM_COUNTERS    = 115,
  parameter int COUNTER_WIDTH   = 7,
  parameter int AXIS_DATA_WIDTH = 64
) (
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]                                    snapshot,
  input  logic [idx_width(calc_num_beats(NUM_COUNTERS, AXIS_DATA_WIDTH, COUNTER_WIDTH))-1:0] beat_idx,
  output logic [AXIS_DATA_WIDTH-1:0]                                               beat_data
);

  localparam int CPB = calc_cpb(AXIS_DATA_WIDTH, COUNTER_WIDTH);

  // One lane per counter slot; slots beyond the last counter read as zero.
  for (genvar j = 0; j < CPB; j++) begin : g_slot
    logic [31:0] counter_idx;
    assign counter_idx = 32'(beat_idx) * 32'(CPB) + 32'(j);
    assign beat_data[j*COUNTER_WIDTH +: COUNTER_WIDTH] =
      (counter_idx < 32'(NUM_COUNTERS)) ? snapshot[counter_idx*COUNTER_WIDTH +: COUNTER_WIDTH]
                                        : '0;
  end

  // High bits that cannot hold a whole counter are always zero.
  if (CPB * COUNTER_WIDTH < AXIS_DATA_WIDTH) begin : g_pad
    assign beat_data[AXIS_DATA_WIDTH-1:CPB*COUNTER_WIDTH] = '0;
  end

endmodule
`default_nettype wire

// File: rtl/perf_counter_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_stream_packer
//  Purpose  : On trigger, freezes the event counter bank into a snapshot,
//             pulses counters_clr for one cycle, then streams the snapshot as
//             AXI-Stream beats to the DMA. Triggers arriving while a frame is
//             in flight are dropped and counted (saturating).
//  Options  : PERF_PACKER_TIMESTAMP_EN - prepend a header beat carrying a
//             64-bit free-running cycle count captured with the snapshot.
//  Revision : 1.0 - initial release
// ============================================================================
module perf_counter_stream_packer
  import perf_packer_pkg::*;
#(
  parameter int NUM_COUNTERS    = 115,
  parameter int COUNTER_WIDTH   = 7,
  parameter int AXIS_DATA_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_flat,
  input  logic                                  trigger,
  output logic                                  counters_clr,
  output logic                                  busy,
  output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [DROPPED_WIDTH-1:0]              dropped_triggers
);

  localparam int NUM_BEATS = calc_num_beats(NUM_COUNTERS, AXIS_DATA_WIDTH, COUNTER_WIDTH);
`ifdef PERF_PACKER_TIMESTAMP_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif
  localparam int FRAME_BEATS = NUM_BEATS + HDR_BEATS;
  localparam int FRAME_IDX_W = idx_width(FRAME_BEATS);
  localparam int BEAT_IDX_W  = idx_width(NUM_BEATS);
  localparam logic [FRAME_IDX_W-1:0] LAST_IDX = FRAME_IDX_W'(FRAME_BEATS - 1);

  state_t                                state;
  logic [FRAME_IDX_W-1:0]                beat_idx;
  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] snapshot;
  logic                                  tvalid_q;
  logic [DROPPED_WIDTH-1:0]              dropped_q;
  logic [BEAT_IDX_W-1:0]                 sel_idx;
  logic [AXIS_DATA_WIDTH-1:0]            slice_data;
  logic                                  handshake;
  logic                                  accept_trigger;

  assign handshake      = tvalid_q & m_axis_tready;
  assign accept_trigger = trigger & (state == IDLE);

`ifdef PERF_PACKER_TIMESTAMP_EN
  logic [TIMESTAMP_WIDTH-1:0] ts_count;
  logic [TIMESTAMP_WIDTH-1:0] ts_snap;

  // Free-running cycle counter used as the frame timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_count <= '0;
    else        ts_count <= ts_count + 1'b1;
  end
`endif

  // Frame beat index minus the header (wraps at the header beat, which is
  // overridden below so the wrapped value is never visible).
  assign sel_idx = BEAT_IDX_W'(beat_idx - FRAME_IDX_W'(HDR_BEATS));

  perf_beat_select #(
    .NUM_COUNTERS    (NUM_COUNTERS),
    .COUNTER_WIDTH   (COUNTER_WIDTH),
    .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH)
  ) u_beat_select (
    .snapshot  (snapshot),
    .beat_idx  (sel_idx),
    .beat_data (slice_data)
  );

  // Frame sequencer: capture on trigger in IDLE, advance on each handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_idx <= '0;
      snapshot <= '0;
      tvalid_q <= 1'b0;
`ifdef PERF_PACKER_TIMESTAMP_EN
      ts_snap  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            snapshot <= counters_flat;
            beat_idx <= '0;
            tvalid_q <= 1'b1;
            state    <= SEND;
`ifdef PERF_PACKER_TIMESTAMP_EN
            ts_snap  <= ts_count;
`endif
          end
        end
        SEND: begin
          if (handshake) begin
            if (beat_idx == LAST_IDX) begin
              beat_idx <= '0;
              tvalid_q <= 1'b0;
              state    <= IDLE;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of triggers that arrive while a frame is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dropped_q <= '0;
    end else if (trigger && (state == SEND) && (dropped_q != '1)) begin
      dropped_q <= dropped_q + 1'b1;
    end
  end

  // Clear pulse is asserted in the same cycle the trigger is accepted so the
  // bank restarts on the edge that freezes the snapshot.
  assign counters_clr     = rst_n & accept_trigger;
  assign busy             = (state == SEND);
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tvalid_q & (beat_idx == LAST_IDX);
  assign dropped_triggers = dropped_q;

`ifdef PERF_PACKER_TIMESTAMP_EN
  assign m_axis_tdata = !tvalid_q          ? '0 :
                        (beat_idx == '0)   ? AXIS_DATA_WIDTH'(ts_snap) :
                                             slice_data;
`else
  assign m_axis_tdata = tvalid_q ? slice_data : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perf_counter_stream_packer
//  Purpose  : Self-checking bench for perf_counter_stream_packer. Frames are
//             collected beat by beat and unpacked back into counter values,
//             which are compared with the values the bench drove at trigger.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_perf_counter_stream_packer;

  localparam int NC  = 115;
  localparam int CW  = 7;
  localparam int DW  = 64;
  localparam int CPB = 9;
  localparam int NB  = 13;
`ifdef PERF_PACKER_TIMESTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FB = NB + HDR;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC*CW-1:0]  counters_flat;
  logic              trigger;
  logic              counters_clr;
  logic              busy;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [15:0]       dropped_triggers;

  int n_checks = 0;
  int n_pass   = 0;
  int snap[NC];
  logic [DW-1:0] beats[$];
  bit            lasts[$];

  perf_counter_stream_packer #(
    .NUM_COUNTERS    (NC),
    .COUNTER_WIDTH   (CW),
    .AXIS_DATA_WIDTH (DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .counters_flat    (counters_flat),
    .trigger          (trigger),
    .counters_clr     (counters_clr),
    .busy             (busy),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .dropped_triggers (dropped_triggers)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_counters();
    for (int k = 0; k < NC; k++) counters_flat[k*CW +: CW] = 7'(snap[k]);
  endtask

  task automatic random_snap();
    for (int k = 0; k < NC; k++) snap[k] = int'($urandom_range(0, 127));
    drive_counters();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trigger = 1'b0; m_axis_tready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Raise trigger for one cycle from IDLE; the first beat must follow at once.
  task automatic start_frame(input string tag);
    trigger = 1'b1;
    #1;
    n_checks++;
    if (counters_clr !== 1'b1) $display("FAIL %s clr_pulse: got %b want 1", tag, counters_clr);
    else n_pass++;
    tick();
    trigger = 1'b0;
    counters_flat = '1;  // snapshot must ignore this
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || counters_clr !== 1'b0)
      $display("FAIL %s first_beat: tvalid=%b busy=%b clr=%b want 1 1 0", tag, m_axis_tvalid, busy, counters_clr);
    else n_pass++;
  endtask

  // Accept beats until tlast, checking that stalled beats are held.
  task automatic collect(input string tag, input bit rnd, output int cycles);
    logic [DW-1:0] held;
    bit stalled;
    bit done;
    int c;
    beats.delete(); lasts.delete();
    stalled = 0; done = 0; c = 0; held = '0;
    while (!done && c < 2000) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held)
          $display("FAIL %s stall_hold: tvalid=%b tdata=%h want 1 %h", tag, m_axis_tvalid, m_axis_tdata, held);
        else n_pass++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back(m_axis_tdata);
        lasts.push_back(m_axis_tlast);
        if (m_axis_tlast) done = 1;
        stalled = 0;
      end else if (m_axis_tvalid) begin
        stalled = 1;
        held = m_axis_tdata;
      end
      c++;
      tick();
    end
    m_axis_tready = 1'b0;
    cycles = c;
    n_checks++;
    if (!done) $display("FAIL %s frame_timeout: got %0d beats, no tlast", tag, beats.size());
    else n_pass++;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s idle_gap: tvalid=%b busy=%b want 0 0", tag, m_axis_tvalid, busy);
    else n_pass++;
  endtask

  // Unpack collected beats back into counters and compare with the model.
  task automatic verify_frame(input string tag);
    int used;
    int b;
    logic [DW-1:0] w;
    n_checks++;
    if (beats.size() != FB) begin
      $display("FAIL %s beat_count: got %0d want %0d", tag, beats.size(), FB);
      return;
    end
    n_pass++;
    for (int i = 0; i < FB; i++) begin
      n_checks++;
      if (lasts[i] !== (i == FB - 1)) $display("FAIL %s tlast_beat%0d: got %b want %b", tag, i, lasts[i], (i == FB - 1));
      else n_pass++;
    end
    for (int cb = 0; cb < NB; cb++) begin
      used = (NC - cb * CPB < CPB) ? NC - cb * CPB : CPB;
      w = beats[cb + HDR] >> (used * CW);
      n_checks++;
      if (w !== '0) $display("FAIL %s pad_beat%0d: got %h want 0", tag, cb, w);
      else n_pass++;
    end
    for (int k = 0; k < NC; k++) begin
      b = k / CPB + HDR;
      w = (beats[b] >> ((k % CPB) * CW)) & 64'h7F;
      n_checks++;
      if (w !== 64'(snap[k])) $display("FAIL %s counter%0d: got %0d want %0d", tag, k, w, snap[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trigger = 1'b1; m_axis_tready = 1'b1; counters_flat = '1;
    tick(); tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
        busy !== 1'b0 || dropped_triggers !== 16'd0 || counters_clr !== 1'b0)
      $display("FAIL reset_state: tvalid=%b tlast=%b tdata=%h busy=%b dropped=%0d clr=%b want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, dropped_triggers, counters_clr);
    else n_pass++;
    trigger = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    do_reset();
    for (int k = 0; k < NC; k++) snap[k] = k % 128;
    drive_counters();
    start_frame("basic");
    collect("basic", 1'b0, cyc);
    n_checks++;
    if (cyc != FB) $display("FAIL basic consecutive: got %0d cycles want %0d", cyc, FB);
    else n_pass++;
    verify_frame("basic");
  endtask

  task automatic test_random_stall();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      random_snap();
      start_frame("stall");
      collect("stall", 1'b1, cyc);
      verify_frame("stall");
    end
  endtask

  task automatic test_dropped();
    int cyc;
    int hs;
    bit seen_last;
    do_reset();
    random_snap();
    start_frame("drop");
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1;
      #1;
      n_checks++;
      if (counters_clr !== 1'b0) $display("FAIL drop clr_while_busy: got %b want 0", counters_clr);
      else n_pass++;
      tick();
      trigger = 1'b0;
      tick();
    end
    n_checks++;
    if (dropped_triggers !== 16'd3) $display("FAIL drop count3: got %0d want 3", dropped_triggers);
    else n_pass++;
    m_axis_tready = 1'b1;
    hs = 0; seen_last = 0;
    for (int c = 0; c < 100 && !seen_last; c++) begin
      #1;
      if (m_axis_tvalid) hs++;
      if (m_axis_tvalid && m_axis_tlast) begin
        trigger = 1'b1;
        seen_last = 1;
      end
      tick();
      trigger = 1'b0;
    end
    m_axis_tready = 1'b0;
    n_checks++;
    if (!seen_last || hs != FB) $display("FAIL drop single_frame: got %0d beats last=%b want %0d", hs, seen_last, FB);
    else n_pass++;
    #1;
    n_checks++;
    if (dropped_triggers !== 16'd4 || m_axis_tvalid !== 1'b0)
      $display("FAIL drop last_hs_trigger: dropped=%0d tvalid=%b want 4 0", dropped_triggers, m_axis_tvalid);
    else n_pass++;
    random_snap();
    start_frame("drop_next");
    collect("drop_next", 1'b0, cyc);
    verify_frame("drop_next");
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    do_reset();
    random_snap();
    start_frame("rstmid");
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || dropped_triggers !== 16'd0 || m_axis_tlast !== 1'b0)
      $display("FAIL rstmid abort: tvalid=%b busy=%b dropped=%0d tlast=%b want 0 0 0 0",
               m_axis_tvalid, busy, dropped_triggers, m_axis_tlast);
    else n_pass++;
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL rstmid no_resume: tvalid=%b want 0", m_axis_tvalid);
    else n_pass++;
    random_snap();
    start_frame("rstmid_new");
    collect("rstmid_new", 1'b0, cyc);
    verify_frame("rstmid_new");
  endtask

  task automatic test_saturation();
    int cyc;
    do_reset();
    m_axis_tready = 1'b0;
    trigger = 1'b1;
    tick();
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (i == 1000) begin
        n_checks++;
        if (dropped_triggers !== 16'd1000) $display("FAIL sat mid_count: got %0d want 1000", dropped_triggers);
        else n_pass++;
      end
    end
    n_checks++;
    if (dropped_triggers !== 16'hFFFF) $display("FAIL sat saturate: got %h want ffff", dropped_triggers);
    else n_pass++;
    trigger = 1'b0;
    collect("sat_drain", 1'b0, cyc);
    n_checks++;
    if (beats.size() != FB) $display("FAIL sat drain_len: got %0d want %0d", beats.size(), FB);
    else n_pass++;
  endtask

`ifdef PERF_PACKER_TIMESTAMP_EN
  task automatic test_timestamp();
    int cyc;
    do_reset();
    random_snap();
    for (int i = 0; i < 100; i++) tick();
    start_frame("ts");
    collect("ts", 1'b0, cyc);
    n_checks++;
    if (beats.size() < 1 || beats[0] !== 64'd100)
      $display("FAIL ts header: got %0d want 100", (beats.size() > 0) ? beats[0] : 64'd0);
    else n_pass++;
    verify_frame("ts");
  endtask
`endif

  initial begin
    rst_n = 1'b0; trigger = 1'b0; m_axis_tready = 1'b0; counters_flat = '0;
    test_reset();
    test_basic();
    test_random_stall();
    test_dropped();
    test_reset_mid_frame();
`ifdef PERF_PACKER_TIMESTAMP_EN
    test_timestamp();
`endif
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
